// File: rtl/uart_arb_pkg.sv
// Shared types and default sizes for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned NREQ_DEF        = 4;
  localparam int unsigned DW_DEF          = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;
  localparam int unsigned TO_CNT_W        = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    START      = 2'd1,
    WAIT_CLEAR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after last_grant,
// wrapping modulo NREQ.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    found
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last_grant) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX byte interface between NREQ requesters.
// Optional watchdog on the start/clear handshake: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_clear_req,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    arb_busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   grant_id_d;
  logic [IW-1:0]   winner;
  logic            found;
  logic [NREQ-1:0] req_ready_d, req_done_d;
  logic            tx_start_d, arb_busy_d;
  logic [DW-1:0]   tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                timeout_err_d;
  logic                to_hit;
`endif

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .found      (found)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id;
    tx_data_d    = tx_data;
    tx_start_d   = tx_start;
    req_ready_d  = '0;
    req_done_d   = '0;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
    to_hit        = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = START;
          last_grant_d = winner;
          grant_id_d   = winner;
          req_ready_d  = NREQ'(1) << winner;
          tx_start_d   = 1'b1;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) tx_data_d = req_data[i*DW +: DW];
          end
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        if (tx_clear_req) begin
          req_done_d = NREQ'(1) << grant_id;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog overrides the handshake and abandons the byte without a done.
    if (state_q != IDLE) begin
      if (to_hit) begin
        timeout_err_d = 1'b1;
        tx_start_d    = 1'b0;
        req_done_d    = '0;
        state_d       = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TO_CNT_W'(1);
      end
    end
`endif
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      grant_id     <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      req_ready    <= '0;
      req_done     <= '0;
      arb_busy     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id     <= grant_id_d;
      tx_data      <= tx_data_d;
      tx_start     <= tx_start_d;
      req_ready    <= req_ready_d;
      req_done     <= req_done_d;
      arb_busy     <= arb_busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_err  <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a randomized UART TX model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready, req_done;
  logic                tx_start;
  logic [DW-1:0]       tx_data;
  logic                tx_busy = 1'b0;
  logic                tx_clear_req = 1'b0;
  logic [1:0]          grant_id;
  logic                arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic                timeout_err;
`endif

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .DW  (DW)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(20)
`endif
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .req_done     (req_done),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       exp_q[$];
  logic [7:0] rq[NREQ][$];    // requester-side byte FIFOs
  logic [7:0] pend[NREQ][$];  // bytes staged for the next commit
  logic [7:0] pm[NREQ][$];    // reference-model copy of the staged bytes
  int         m_last = NREQ - 1;

  logic uart_en    = 1'b1;
  logic clear_real = 1'b0;

  logic open = 1'b0;
  int   cur_id = 0;
  logic [7:0] cur_data = '0;
  int   cyc = 0;
  int   last_done = -10;
  logic rst_seen = 1'b0, busy_seen = 1'b0, done_due = 1'b0;

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // Requester side: a requester pops its byte on accept, holds valid while non-empty.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]         = (rq[i].size() != 0);
        req_data[i*DW +: DW] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
      end
    end
  end

  // UART TX model: random start-to-busy delay, optional early clear, random frame time.
  initial begin
    int d1, f;
    forever begin
      @(posedge clk); #1;
      if (uart_en && tx_start && !tx_busy && !wb_rst_i) begin
        d1 = $urandom_range(0, 3);
        for (int k = 0; k < d1; k++) begin
          if (k == 0 && $urandom_range(0, 1) == 1) begin
            tx_clear_req = 1'b1;
            clear_real   = 1'b0;
          end
          @(posedge clk); #1;
          tx_clear_req = 1'b0;
        end
        tx_busy = 1'b1;
        f = $urandom_range(2, 10);
        repeat (f) begin @(posedge clk); #1; end
        tx_busy      = 1'b0;
        tx_clear_req = 1'b1;
        clear_real   = 1'b1;
        @(posedge clk); #1;
        tx_clear_req = 1'b0;
        clear_real   = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on accepts and checks handshake responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        rst_seen = 1'b0; open = 1'b0; busy_seen = 1'b0; done_due = 1'b0;
      end else begin
        if (open) check("tx_data_held", tx_data == cur_data, 32'(tx_data), 32'(cur_data));
        if (busy_seen) begin
          check("tx_start_drop", tx_start == 1'b0, 32'(tx_start), 32'd0);
          busy_seen = 1'b0;
        end
        if (done_due) begin
          check("done_pulse", req_done == oh(cur_id), 32'(req_done), 32'(oh(cur_id)));
          check("done_idle", arb_busy == 1'b0, 32'(arb_busy), 32'd0);
          open = 1'b0; last_done = cyc; done_due = 1'b0;
        end else if (req_done != '0) begin
          check("no_done", req_done == '0, 32'(req_done), 32'd0);
        end
        if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            check("ready_expected", exp_q.size() != 0, 32'(req_ready), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ready_id", req_ready == oh(e.id), 32'(req_ready), 32'(oh(e.id)));
            check("grant_id", int'(grant_id) == e.id, 32'(grant_id), 32'(e.id));
            check("ready_data", tx_data == e.data, 32'(tx_data), 32'(e.data));
            check("ready_start_busy", tx_start && arb_busy, 32'({tx_start, arb_busy}), 32'd3);
            check("ready_spacing", !open && cyc > last_done, 32'(cyc), 32'(last_done + 1));
            open = 1'b1; cur_id = e.id; cur_data = e.data;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (timeout_err) begin open = 1'b0; last_done = cyc; end
`endif
      end
      if (wb_rst_i) rst_seen = 1'b1;
      else begin
        if (tx_start && tx_busy) busy_seen = 1'b1;
        if (tx_clear_req && clear_real) done_due = 1'b1;
      end
    end
  end

  task automatic add_byte(input int id, input logic [7:0] d);
    pend[id].push_back(d);
    pm[id].push_back(d);
  endtask

  // Reference model: round-robin over non-empty requesters, one byte per grant.
  task automatic commit();
    int w;
    logic [7:0] b;
    exp_t e;
    @(posedge clk); #1;
    forever begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (w < 0 && pm[c].size() != 0) w = c;
      end
      if (w < 0) break;
      b = pm[w].pop_front();
      e.id = w; e.data = b;
      exp_q.push_back(e);
      m_last = w;
    end
    for (int i = 0; i < NREQ; i++)
      while (pend[i].size() != 0) rq[i].push_back(pend[i].pop_front());
  endtask

  task automatic wait_drain(input string name);
    int n;
    logic busy_any;
    n = 0;
    busy_any = 1'b1;
    while (busy_any && n < 4000) begin
      @(negedge clk);
      n++;
      busy_any = (exp_q.size() != 0) || open;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) busy_any = 1'b1;
    end
    if (busy_any) check(name, 1'b0, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready(input int id, input string name);
    int n;
    n = 0;
    while (!req_ready[id] && n < 200) begin @(negedge clk); n++; end
    if (!req_ready[id]) check(name, 1'b0, 32'(req_ready), 32'(oh(id)));
  endtask

  initial begin
    logic [7:0] fa, fb, fc, fd;
    exp_t e;
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready, req_done, tx_start, tx_data, grant_id, arb_busy} == '0,
          32'({req_ready, req_done, tx_start, tx_data, grant_id, arb_busy}), 32'd0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;

    // Single request from requester 0
    add_byte(0, 8'h41);
    commit();
    wait_drain("single_drain");

    // Fairness: requester 2 keeps a byte pending, requester 1 arrives mid-transfer
    fa = 8'($urandom); fb = 8'($urandom); fc = 8'($urandom); fd = 8'($urandom);
    e.id = 2; e.data = fa; exp_q.push_back(e);
    e.id = 1; e.data = fb; exp_q.push_back(e);
    e.id = 2; e.data = fc; exp_q.push_back(e);
    e.id = 2; e.data = fd; exp_q.push_back(e);
    @(posedge clk); #1;
    rq[2].push_back(fa); rq[2].push_back(fc); rq[2].push_back(fd);
    wait_ready(2, "fair_first_ready");
    @(posedge clk); #1;
    rq[1].push_back(fb);
    m_last = 2;
    wait_drain("fair_drain");

    // tx_busy while idle must not start anything
    uart_en = 1'b0;
    @(posedge clk); #1;
    tx_busy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_busy_ignored", !arb_busy && !tx_start, 32'({arb_busy, tx_start}), 32'd0);
    @(posedge clk); #1;
    tx_busy = 1'b0;

    // Reset in WAIT_CLEAR with requester 3 granted
    add_byte(3, 8'hA5);
    commit();
    wait_ready(3, "rst_ready3");
    @(posedge clk); #1;
    tx_busy = 1'b1;
    @(posedge clk); #1;
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", {req_ready, req_done, tx_start, tx_data, grant_id, arb_busy} == '0,
          32'({req_ready, req_done, tx_start, tx_data, grant_id, arb_busy}), 32'd0);
    m_last = NREQ - 1;
    repeat (5) @(negedge clk);
    uart_en = 1'b1;

    // Contention from a fresh pointer: expect 0,1,2,3,0
    add_byte(0, 8'h10); add_byte(1, 8'h11); add_byte(2, 8'h12); add_byte(3, 8'h13);
    add_byte(0, 8'h14);
    commit();
    wait_drain("contention_drain");

    // Randomized batches
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) add_byte(i, 8'($urandom));
      end
      commit();
      wait_drain("random_drain");
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no tx_busy ever arrives
    uart_en = 1'b0;
    add_byte(1, 8'h5A);
    commit();
    wait_ready(1, "to_ready");
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    check("timeout_latency", n == 20, 32'(n), 32'd20);
    check("timeout_state", !tx_start && !arb_busy && grant_id == 2'd1,
          32'({tx_start, arb_busy, grant_id}), 32'd1);
    uart_en = 1'b1;
    add_byte(2, 8'hC3); add_byte(1, 8'h3C);
    commit();
    wait_drain("after_timeout_drain");
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (tx_start / tx_data / tx_busy / tx_clear_req byte interface) between NREQ on-chip requesters, e.g. firmware mailbox, DMA and a debug path. It uses round-robin arbitration and sequences one byte at a time through the transmitter's start → busy → clear handshake. Each requester gets an accept pulse and a completion pulse. The block sits between the requester-side logic in the user project and the UART TX engine.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data byte width
- TIMEOUT_CYC, 65535, watchdog limit in clocks (used only with UART_ARB_TIMEOUT_EN)

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester byte-pending request, level
- req_data  in  NREQ*DW  requester i byte at [i*DW +: DW]
- req_ready  out  NREQ  one-cycle accept pulse; at most one bit set
- req_done  out  NREQ  one-cycle completion pulse for the granted requester
- tx_start  out  1  start request to UART TX
- tx_data  out  DW  byte to UART TX; stable while tx_start=1 and until clear
- tx_busy  in  1  UART TX busy
- tx_clear_req  in  1  UART TX one-cycle frame-complete pulse
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- arb_busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle watchdog pulse (present only with UART_ARB_TIMEOUT_EN)

## Operation
- Reset values: all outputs 0; state IDLE; rr pointer last_grant = NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- States are IDLE → START → WAIT_CLEAR → IDLE.
- IDLE, when any req_valid is set:
  - Pick the first set bit searching from last_grant+1 upward, with wrap-around modulo NREQ.
  - Latch the winner's req_data into tx_data.
  - Set grant_id and last_grant to the winner.
  - Pulse req_ready[winner].
  - Go to START.
- START:
  - tx_start=1.
  - When tx_busy=1 is sampled: tx_start←0, go to WAIT_CLEAR.
  - tx_clear_req is ignored in START.
- WAIT_CLEAR:
  - tx_data is held.
  - When tx_clear_req=1 is sampled: pulse req_done[grant_id], go to IDLE.
- Arbitration is never performed in the same cycle as completion. A new grant is issued no earlier than the cycle after returning to IDLE.
- req_valid changes after acceptance have no effect on the in-flight byte.
- A requester that keeps req_valid high is re-served only after every other pending requester has had one grant.
- req_valid of the requester being served, sampled in IDLE after done, counts as a new byte.
- tx_busy high while in IDLE is ignored.

## Timing
- req_valid high in IDLE at edge N: req_ready, tx_start and arb_busy are high after edge N.
- tx_busy sampled high at edge M: tx_start is low after edge M.
- tx_clear_req sampled at edge K: req_done pulses after edge K; state is IDLE after K; the next req_ready is no earlier than after edge K+1.
- Minimum request-to-request spacing is 3 cycles plus UART frame time.
- wb_rst_i is synchronous and overrides everything, including mid-transfer:
  - tx_start drops after the reset edge.
  - No req_done is issued for the aborted byte.
  - The rr pointer resets.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entering START and counts in START and WAIT_CLEAR.
  - On reaching TIMEOUT_CYC: timeout_err pulses for one cycle, tx_start←0, no req_done, state←IDLE; grant_id keeps the failed requester.
- Undefined: no counter and no timeout_err port; the block waits indefinitely for tx_busy and tx_clear_req.

## Structure
- Package uart_arb_pkg holds:
  - the state typedef (IDLE, START, WAIT_CLEAR)
  - the default widths (DW=8)
  - the default TIMEOUT_CYC
- Sub-module rr_picker: combinational round-robin priority search. Inputs are the req vector and last_grant; outputs are the winner index and a found flag.

## Test plan
- Single request: req_valid=4'b0001, data 0x41; tx_busy high 2 cycles after tx_start, clear 10 cycles later. Expect: one req_ready[0], tx_data=0x41 held throughout, req_done[0] after clear.
- Contention: all four valid with data 0x10..0x13, held. Expect grants in order 0,1,2,3,0 with matching bytes; each done precedes the next ready by at least 1 cycle.
- Fairness: req 2 held high continuously, req 1 raised mid-transfer. Expect next grant 1 then 2; never two consecutive grants to 2 while 1 is pending.
- Early clear: tx_clear_req pulsed while in START, before tx_busy. Expect no req_done; the block stays in START until busy, then completes on a later clear.
- Reset mid-transfer: wb_rst_i for 1 cycle during WAIT_CLEAR with req 3 granted. Expect all outputs 0 next cycle, no req_done[3], next grant from requester 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=20: tx_busy never asserted. Expect timeout_err 20 cycles after START entry, tx_start low, state IDLE, next request served.
